// File: rtl/display_pkg.sv
// Shared constants and types for the BCD display formatter.
package display_pkg;

    localparam int unsigned NUM_DIGITS     = 8;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned DATA_W         = NUM_DIGITS * DIGIT_W;
    localparam int unsigned BIN_W_DEF      = 27;
    localparam int unsigned MAX_VAL_DEF    = 99_999_999;
    localparam logic [DIGIT_W-1:0] BLANK_CODE_DEF = 4'hF;
    localparam logic [DATA_W-1:0]  SAT_WORD       = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef logic [DATA_W-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: values of 5 or more get +3.
module bcd_add3_digit
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj_c
);

    always_comb begin
        adj_c = digit;
        if (digit >= DIGIT_W'(5)) begin
            adj_c = digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_display_formatter.sv
// Iterative binary-to-BCD converter feeding the 8-digit display scanner,
// with saturation above MAX_VAL and optional leading-zero blanking.
module bcd_display_formatter
    import display_pkg::*;
#(
    parameter int unsigned         BIN_W      = BIN_W_DEF,
    parameter logic [DIGIT_W-1:0]  BLANK_CODE = BLANK_CODE_DEF,
    parameter int unsigned         MAX_VAL    = MAX_VAL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin,
    input  logic              blank_en,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned ACC_W = DATA_W + BIN_W;

    state_t state, state_next;

    bcd_word_t          bcd, bcd_d;
    logic [BIN_W-1:0]   bin_sh, bin_sh_d;
    logic [BIN_W-1:0]   bin_cap, bin_cap_d;
    logic               blank_cap, blank_cap_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               busy_d, done_d, ovf_d;
    bcd_word_t          data_d;

    bcd_word_t          bcd_adj;
    logic [ACC_W-1:0]   acc_next;
    bcd_word_t          bcd_next;
    logic               over_c;
    bcd_word_t          result;
    logic               lead_zero;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit (bcd[g*DIGIT_W +: DIGIT_W]),
            .adj_c (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Correct every digit, then shift the whole {bcd, bin} accumulator left by one.
    assign acc_next = {bcd_adj, bin_sh} << 1;
    assign bcd_next = acc_next[ACC_W-1:BIN_W];
    assign over_c   = 32'(bin_cap) > MAX_VAL;

    // Final display word: saturate, else blank digits above the highest nonzero one.
    always_comb begin
        result    = bcd_next;
        lead_zero = 1'b1;
        if (over_c) begin
            result = SAT_WORD;
        end else if (blank_cap) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                if (bcd_next[i*DIGIT_W +: DIGIT_W] != '0) begin
                    lead_zero = 1'b0;
                end
                if (lead_zero) begin
                    result[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the datapath and output registers.
    always_comb begin
        bcd_d       = bcd;
        bin_sh_d    = bin_sh;
        bin_cap_d   = bin_cap;
        blank_cap_d = blank_cap;
        cnt_d       = cnt;
        busy_d      = busy;
        done_d      = 1'b0;
        ovf_d       = ovf;
        data_d      = data;
        unique case (state)
            IDLE: begin
                if (start) begin
                    bin_cap_d   = bin;
                    bin_sh_d    = bin;
                    blank_cap_d = blank_en;
                    bcd_d       = '0;
                    cnt_d       = CNT_W'(BIN_W);
                    busy_d      = 1'b1;
                end
            end
            SHIFT: begin
                bcd_d    = bcd_next;
                bin_sh_d = acc_next[BIN_W-1:0];
                cnt_d    = cnt - CNT_W'(1);
                // Publish on the last shift so done lands in the FINISH cycle with busy still high.
                if (cnt == CNT_W'(1)) begin
                    data_d = result;
                    ovf_d  = over_c;
                    done_d = 1'b1;
                end
            end
            FINISH: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd       <= '0;
            bin_sh    <= '0;
            bin_cap   <= '0;
            blank_cap <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            data      <= '0;
        end else begin
            bcd       <= bcd_d;
            bin_sh    <= bin_sh_d;
            bin_cap   <= bin_cap_d;
            blank_cap <= blank_cap_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            ovf       <= ovf_d;
            data      <= data_d;
        end
    end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Self-checking bench: directed scenarios plus random traffic against an arithmetic reference model.
module tb_bcd_display_formatter;

    localparam int unsigned BIN_W = 27;
    localparam int unsigned MAXV  = 99_999_999;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic             blank_en = 1'b0;
    logic [BIN_W-1:0] bin      = '0;
    logic             busy, done, ovf;
    logic [31:0]      data;

    int checks = 0;
    int errors = 0;

    bcd_display_formatter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .blank_en (blank_en),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .data     (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decimal digits by division; blanked when above the value's most significant digit.
    function automatic logic [31:0] fmt(input int unsigned v, input bit bl);
        logic [31:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        if (v > MAXV) return 32'h9999_9999;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            if (bl && i > 0 && v < p) r[i*4 +: 4] = 4'hF;
            p = p * 10;
        end
        return r;
    endfunction

    // Reference timing: accepted at cycle 0, done in cycle BIN_W+1, idle again one cycle later.
    bit          m_active;
    int unsigned m_age;
    int unsigned m_val;
    bit          m_blank;
    logic [31:0] m_data;
    bit          m_ovf, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_val    <= 0;
            m_blank  <= 1'b0;
            m_data   <= '0;
            m_ovf    <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                m_age <= m_age + 1;
                if (m_age + 1 == BIN_W) begin
                    m_data <= fmt(m_val, m_blank);
                    m_ovf  <= (m_val > MAXV);
                    m_done <= 1'b1;
                end
                if (m_age + 1 == BIN_W + 1) m_active <= 1'b0;
            end else if (start) begin
                m_active <= 1'b1;
                m_age    <= 0;
                m_val    <= 32'(bin);
                m_blank  <= blank_en;
            end
        end
    end

    logic [31:0] prev_data = '0;
    bit          prev_done = 1'b0;

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("ovf",  32'(ovf),  32'(m_ovf));
        check("data", data, m_data);
        if (rst_n) begin
            if (data !== prev_data) check("data_change_without_done", 32'(done), 32'd1);
            check("done_back_to_back", 32'(done & prev_done), 32'd0);
        end
        prev_data <= data;
        prev_done <= done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 80 && busy; n++) tick();
        if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic convert(input int unsigned v, input bit bl, input logic [31:0] exp_data,
                           input bit exp_ovf, input string name);
        int n;
        wait_idle(name);
        bin      = BIN_W'(v);
        blank_en = bl;
        start    = 1'b1;
        tick();
        start = 1'b0;
        bin   = BIN_W'($urandom);
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_latency"}, 32'(n), 32'(BIN_W + 1));
        check({name, "_busy_on_done"}, 32'(busy), 32'd1);
        check({name, "_data"}, data, exp_data);
        check({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        tick();
    endtask

    function automatic int unsigned rand_val();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 9);
            1:       return $urandom_range(0, 99_999);
            2:       return $urandom_range(99_999_990, 100_000_010);
            default: return $urandom_range(0, 134_217_727);
        endcase
    endfunction

    initial begin
        int nd;
        int last;
        int unsigned rv;
        bit rb;

        repeat (3) @(negedge clk);
        check("reset_data", data, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        convert(12_345_678, 1'b0, 32'h1234_5678, 1'b0, "t1");
        convert(1_234,      1'b1, 32'hFFFF_1234, 1'b0, "t2_blank");
        convert(0,          1'b1, 32'hFFFF_FFF0, 1'b0, "t2_zero");
        convert(100_000_000, 1'b0, 32'h9999_9999, 1'b1, "t3_ovf");
        convert(5,          1'b0, 32'h0000_0005, 1'b0, "t3_after_ovf");
        convert(99_999_999, 1'b1, 32'h9999_9999, 1'b0, "max_val");
        convert(134_217_727, 1'b1, 32'h9999_9999, 1'b1, "all_ones");
        convert(10_000_000, 1'b1, 32'h1000_0000, 1'b0, "top_digit_only");
        convert(90_807,     1'b1, 32'hFFF9_0807, 1'b0, "inner_zeros");
        convert(0,          1'b0, 32'h0000_0000, 1'b0, "zero_no_blank");

        // Start pulses while busy and on the done cycle must be ignored.
        wait_idle("t4");
        bin = BIN_W'(87_654_321); blank_en = 1'b0; start = 1'b1;
        tick();
        nd = 0;
        for (int c = 1; c <= 29; c++) begin
            bin   = BIN_W'(42);
            start = (c == 5 || c == 28);
            @(negedge clk);
            if (done) nd++;
            tick();
        end
        start = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (done) nd++;
            tick();
        end
        check("t4_done_count", 32'(nd), 32'd1);
        check("t4_data", data, 32'h8765_4321);

        // Reset in the middle of a conversion.
        wait_idle("t5");
        bin = BIN_W'(777); blank_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", data, 32'h0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_ovf",  32'(ovf),  32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
            tick();
        end
        check("t5_no_done_after_abort", 32'(nd), 32'd0);
        convert(31_415_926, 1'b0, 32'h3141_5926, 1'b0, "t5_fresh");

        // Start held high: one result every BIN_W+2 cycles.
        wait_idle("t6");
        bin = BIN_W'(99_999_999); blank_en = 1'b0; start = 1'b1;
        nd = 0;
        last = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) check("t6_period", 32'(c - last), 32'd29);
                else check("t6_first_done", 32'(c), 32'd28);
                check("t6_data", data, 32'h9999_9999);
                check("t6_ovf", 32'(ovf), 32'd0);
                last = c;
                nd++;
            end
            tick();
        end
        start = 1'b0;
        check("t6_done_count", 32'(nd), 32'd3);
        wait_idle("t6_end");

        // Random traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 2000; c++) begin
            rv = rand_val();
            rb = 1'($urandom_range(0, 1));
            bin      = BIN_W'(rv);
            blank_en = rb;
            start    = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0;
        repeat (2) tick();
        wait_idle("random_end");
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
